// File: rtl/ins_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: cache geometry, FSM states and reset PC.
package ins_fetcher_pkg;

    localparam int unsigned ICACHE_IDX_BIT = 4;
    localparam int unsigned ICACHE_LINES   = 16;
    localparam logic [31:0] RESET_PC       = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ins_fetcher_icache.sv
// Direct-mapped one-word-per-line instruction cache with combinational lookup.
module icache #(
    parameter int unsigned LINES   = 16,
    parameter int unsigned IDX_BIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] lookup_addr,
    output logic        lookup_hit,
    output logic [31:0] lookup_word,
    input  logic        fill_en,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_word
);

    localparam int unsigned TAG_W = 32 - IDX_BIT - 2;

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];

    logic [IDX_BIT-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [IDX_BIT-1:0] w_fl_idx;
    logic [TAG_W-1:0]   w_fl_tag;
    logic               w_unused;

    assign w_lk_idx = lookup_addr[IDX_BIT+1:2];
    assign w_lk_tag = lookup_addr[31:IDX_BIT+2];
    assign w_fl_idx = fill_addr[IDX_BIT+1:2];
    assign w_fl_tag = fill_addr[31:IDX_BIT+2];
    assign w_unused = ^{lookup_addr[1:0], fill_addr[1:0]};

    assign lookup_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign lookup_word = r_data[w_lk_idx];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[w_fl_idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every hit.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            r_tag[w_fl_idx]  <= w_fl_tag;
            r_data[w_fl_idx] <= fill_word;
        end
    end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: FETCH/WAIT FSM feeding the decoder one word at a time.
// Optional direct-mapped instruction cache enabled with `define ICACHE_EN.
module ins_fetcher
    import ins_fetcher_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        is_stall,
    input  logic [31:0] next_PC,
    output logic        inst_input,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    fetch_state_t r_state, w_state_n;
    logic [31:0]  r_pc, w_pc_n;
    logic [31:0]  r_inst, w_inst_n;
    logic         r_inst_input, w_inst_input_n;
    logic         r_mem_req, w_mem_req_n;
    logic [31:0]  r_mem_addr, w_mem_addr_n;
    logic         r_discard, w_discard_n;

    logic         w_hit;
    logic [31:0]  w_word;
    logic         w_fill_en;

    assign w_fill_en = rdy_in && (r_state == WAIT) && mem_done;

`ifdef ICACHE_EN
    logic [31:0] w_lookup_addr;

    // Look ahead to next_PC on a consume so back-to-back hits keep inst_input high.
    assign w_lookup_addr = (r_inst_input && !is_stall) ? next_PC : r_pc;

    icache #(
        .LINES   (ICACHE_LINES),
        .IDX_BIT (ICACHE_IDX_BIT)
    ) u_icache (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .lookup_addr (w_lookup_addr),
        .lookup_hit  (w_hit),
        .lookup_word (w_word),
        .fill_en     (w_fill_en),
        .fill_addr   (r_mem_addr),
        .fill_word   (mem_data)
    );
`else
    logic w_unused_fill;

    assign w_hit         = 1'b0;
    assign w_word        = '0;
    assign w_unused_fill = w_fill_en;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_input <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_inst       <= w_inst_n;
            r_inst_input <= w_inst_input_n;
            r_mem_req    <= w_mem_req_n;
            r_mem_addr   <= w_mem_addr_n;
            r_discard    <= w_discard_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_inst_n       = r_inst;
        w_inst_input_n = r_inst_input;
        w_mem_req_n    = r_mem_req;
        w_mem_addr_n   = r_mem_addr;
        w_discard_n    = r_discard;
        if (rdy_in) begin
            case (r_state)
                FETCH: begin
                    if (rob_clear) begin
                        w_pc_n         = rob_new_pc;
                        w_inst_input_n = 1'b0;
                    end else if (r_inst_input) begin
                        if (!is_stall) begin
                            w_pc_n         = next_PC;
                            w_inst_input_n = w_hit;
                            if (w_hit) w_inst_n = w_word;
                        end
                    end else if (w_hit) begin
                        w_inst_input_n = 1'b1;
                        w_inst_n       = w_word;
                    end else begin
                        w_mem_req_n  = 1'b1;
                        w_mem_addr_n = word_align(r_pc);
                        w_state_n    = WAIT;
                    end
                end
                WAIT: begin
                    if (rob_clear) w_pc_n = rob_new_pc;
                    // The memory cannot abort, so a flush only marks the returning word for discard.
                    if (mem_done) begin
                        w_mem_req_n = 1'b0;
                        w_state_n   = FETCH;
                        w_discard_n = 1'b0;
                        if (!(r_discard || rob_clear)) begin
                            w_inst_n       = mem_data;
                            w_inst_input_n = 1'b1;
                        end
                    end else if (rob_clear) begin
                        w_discard_n = 1'b1;
                    end
                end
                default: w_state_n = FETCH;
            endcase
        end
    end

    assign inst_input = r_inst_input;
    assign inst       = r_inst;
    assign inst_addr  = r_pc;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

endmodule
